// File: rtl/dff_comb_pipe_pkg.sv
// Shared types and the stage-0 bitwise function for dff_comb_pipe.
// The function works at MAX_WIDTH bits; callers size operands and results with casts.
package dff_comb_pipe_pkg;

    localparam int MAX_WIDTH = 64;

    typedef enum logic [1:0] {
        MODE_OR_NOT = 2'd0,
        MODE_AND    = 2'd1,
        MODE_XOR    = 2'd2,
        MODE_PASS   = 2'd3
    } mode_e;

    function automatic logic [MAX_WIDTH-1:0] comb_fn(
        input mode_e                  mode,
        input logic [MAX_WIDTH-1:0]   b,
        input logic [MAX_WIDTH-1:0]   c
    );
        logic [MAX_WIDTH-1:0] res;
        case (mode)
            MODE_OR_NOT: res = b | ~c;
            MODE_AND:    res = b & c;
            MODE_XOR:    res = b ^ c;
            default:     res = b;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/dff_comb_pipe_stage.sv
// One pipeline register stage: valid plus data (and parity when DFF_COMB_PIPE_PARITY_EN).
// Data only loads on a valid beat so bubbles never toggle the data bits.
module dff_comb_stage #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_en,
    input  logic             i_valid,
    input  logic [WIDTH-1:0] i_data,
`ifdef DFF_COMB_PIPE_PARITY_EN
    input  logic             i_par,
    output logic             o_par,
`endif
    output logic             o_valid,
    output logic [WIDTH-1:0] o_data
);

    logic             r_valid;
    logic [WIDTH-1:0] r_data;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid <= 1'b0;
            r_data  <= '0;
        end else if (i_en) begin
            r_valid <= i_valid;
            if (i_valid) begin
                r_data <= i_data;
            end
        end
    end

`ifdef DFF_COMB_PIPE_PARITY_EN
    logic r_par;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_par <= 1'b0;
        end else if (i_en && i_valid) begin
            r_par <= i_par;
        end
    end

    assign o_par = r_par;
`endif

    assign o_valid = r_valid;
    assign o_data  = r_data;

endmodule

// File: rtl/dff_comb_pipe.sv
// Mode-selected bitwise function on two operands, carried through DEPTH valid/ready stages.
// Optional even-parity sideband enabled by DFF_COMB_PIPE_PARITY_EN. WIDTH must not exceed MAX_WIDTH.
module dff_comb_pipe
    import dff_comb_pipe_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_b,
    input  logic [WIDTH-1:0] in_c,
    input  logic [1:0]       in_mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_d
`ifdef DFF_COMB_PIPE_PARITY_EN
    ,
    output logic             out_par
`endif
);

    logic             w_stall;
    logic [WIDTH-1:0] w_func;

    logic             w_vld_in  [DEPTH];
    logic             w_vld_q   [DEPTH];
    logic [WIDTH-1:0] w_data_in [DEPTH];
    logic [WIDTH-1:0] w_data_q  [DEPTH];

    // The whole pipe moves in lockstep: any stall at the output freezes every stage.
    assign w_stall  = w_vld_q[DEPTH-1] & ~out_ready;
    assign in_ready = ~w_stall;

    assign w_func = WIDTH'(comb_fn(mode_e'(in_mode), MAX_WIDTH'(in_b), MAX_WIDTH'(in_c)));

`ifdef DFF_COMB_PIPE_PARITY_EN
    logic w_par_in [DEPTH];
    logic w_par_q  [DEPTH];
`endif

    for (genvar k = 0; k < DEPTH; k++) begin : g_stage
        if (k == 0) begin : g_head
            assign w_vld_in[k]  = in_valid;
            assign w_data_in[k] = w_func;
`ifdef DFF_COMB_PIPE_PARITY_EN
            assign w_par_in[k]  = ^w_func;
`endif
        end else begin : g_body
            assign w_vld_in[k]  = w_vld_q[k-1];
            assign w_data_in[k] = w_data_q[k-1];
`ifdef DFF_COMB_PIPE_PARITY_EN
            assign w_par_in[k]  = w_par_q[k-1];
`endif
        end

        dff_comb_stage #(.WIDTH(WIDTH)) u_stage (
            .clk     (clk),
            .rst_n   (rst_n),
            .i_en    (~w_stall),
            .i_valid (w_vld_in[k]),
            .i_data  (w_data_in[k]),
`ifdef DFF_COMB_PIPE_PARITY_EN
            .i_par   (w_par_in[k]),
            .o_par   (w_par_q[k]),
`endif
            .o_valid (w_vld_q[k]),
            .o_data  (w_data_q[k])
        );
    end

    assign out_valid = w_vld_q[DEPTH-1];
    assign out_d     = w_data_q[DEPTH-1];
`ifdef DFF_COMB_PIPE_PARITY_EN
    assign out_par   = w_par_q[DEPTH-1];
`endif

endmodule

// File: tb/tb_dff_comb_pipe.sv
// Directed self-checking bench for dff_comb_pipe at WIDTH=8, DEPTH=3.
// Inputs change and outputs are sampled 1 time unit after each rising edge.
module tb_dff_comb_pipe;

    localparam int WIDTH = 8;
    localparam int DEPTH = 3;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_b;
    logic [WIDTH-1:0] in_c;
    logic [1:0]       in_mode;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_d;
`ifdef DFF_COMB_PIPE_PARITY_EN
    logic             out_par;
`endif

    int n_cmp = 0;
    int n_mis = 0;

    always #5 clk = ~clk;

    dff_comb_pipe #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_b      (in_b),
        .in_c      (in_c),
        .in_mode   (in_mode),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_d     (out_d)
`ifdef DFF_COMB_PIPE_PARITY_EN
        ,
        .out_par   (out_par)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_cmp++;
        if (obs !== exp_v) begin
            n_mis++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp_v, $time);
        end
    endtask

    task automatic drive(input logic v, input logic [7:0] b, input logic [7:0] c, input logic [1:0] m);
        in_valid = v;
        in_b     = b;
        in_c     = c;
        in_mode  = m;
        #1;
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        drive(1'b0, 8'h00, 8'h00, 2'd0);
        for (int i = 0; i < n; i++) cyc();
    endtask

    logic [7:0] mode_exp [4] = '{8'hE7, 8'h24, 8'h99, 8'hA5};
    logic [7:0] bp_exp   [5] = '{8'hEF, 8'hEE, 8'hED, 8'hEC, 8'hEB};
    logic [7:0] rx_q [$];

    initial begin
        rst_n     = 1'b0;
        out_ready = 1'b1;
        drive(1'b1, 8'h5A, 8'h3C, 2'd1);

        // Reset held with in_valid asserted
        cyc(); cyc();
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_d",     32'(out_d),     32'h00);
        chk("rst_in_ready",  32'(in_ready),  32'd1);

        // Release between edges; first beat taken on the very next edge
        rst_n = 1'b1;
        drive(1'b1, 8'h0F, 8'h33, 2'd0);
        cyc();
        drive(1'b0, 8'h00, 8'h00, 2'd0);
        cyc();
        chk("first_not_early", 32'(out_valid), 32'd0);
        cyc();
        chk("first_valid", 32'(out_valid), 32'd1);
        chk("first_data",  32'(out_d),     32'hCF);
        idle(4);

        // All four modes back to back; beat at cycle j visible in pre-edge sample of cycle j+3
        for (int j = 0; j < 8; j++) begin
            if (j < 4) drive(1'b1, 8'hA5, 8'h3C, 2'(j));
            else       drive(1'b0, 8'h00, 8'h00, 2'd0);
            if (j >= 3 && j < 7) begin
                chk("mode_valid", 32'(out_valid), 32'd1);
                chk("mode_data",  32'(out_d),     32'(mode_exp[j-3]));
            end else begin
                chk("mode_idle_valid", 32'(out_valid), 32'd0);
            end
            cyc();
        end
        idle(4);

        // Backpressure: out_ready low for cycles 3..6
        begin
            int sent = 0;
            for (int j = 0; j < 30; j++) begin
                out_ready = !(j >= 3 && j <= 6);
                if (sent < 5) drive(1'b1, 8'h10 + 8'(sent), 8'hFF, 2'd2);
                else          drive(1'b0, 8'h00, 8'h00, 2'd0);
                if (j >= 3 && j <= 6) begin
                    chk("bp_in_ready", 32'(in_ready),  32'd0);
                    chk("bp_held_v",   32'(out_valid), 32'd1);
                    chk("bp_held_d",   32'(out_d),     32'hEF);
                end
                if (out_valid && out_ready) rx_q.push_back(out_d);
                if (in_valid && in_ready) sent++;
                cyc();
            end
            out_ready = 1'b1;
            chk("bp_count", 32'(rx_q.size()), 32'd5);
            for (int i = 0; i < 5; i++) begin
                if (i < rx_q.size()) chk("bp_order", 32'(rx_q[i]), 32'(bp_exp[i]));
                else                 chk("bp_missing", 32'd0, 32'(bp_exp[i]));
            end
        end
        idle(2);

        // Bubbles: valid on even cycles 0..6, PASS with b = cycle index
        for (int j = 0; j < 12; j++) begin
            if (j < 8) drive(j % 2 == 0, 8'(j), 8'h00, 2'd3);
            else       drive(1'b0, 8'h00, 8'h00, 2'd0);
            if (j >= 3 && j < 11) begin
                chk("bub_valid", 32'(out_valid), 32'((j - 3) % 2 == 0));
                if ((j - 3) % 2 == 0) chk("bub_data", 32'(out_d), 32'(j - 3));
            end else begin
                chk("bub_idle", 32'(out_valid), 32'd0);
            end
            cyc();
        end
        idle(2);

        // Reset mid-flight with three beats in the pipe
        for (int j = 0; j < 3; j++) begin
            drive(1'b1, 8'h40 + 8'(j), 8'h00, 2'd3);
            cyc();
        end
        drive(1'b0, 8'h00, 8'h00, 2'd0);
        chk("mid_pre_valid", 32'(out_valid), 32'd1);
        chk("mid_pre_data",  32'(out_d),     32'h40);
        #1 rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", 32'(out_valid), 32'd0);
        chk("mid_rst_data",  32'(out_d),     32'h00);
        chk("mid_rst_ready", 32'(in_ready),  32'd1);
        #1 rst_n = 1'b1;
        begin
            int stale = 0;
            for (int j = 0; j < 6; j++) begin
                cyc();
                if (out_valid) stale++;
            end
            chk("mid_no_stale", 32'(stale), 32'd0);
        end

`ifdef DFF_COMB_PIPE_PARITY_EN
        drive(1'b1, 8'h07, 8'h00, 2'd3);
        cyc();
        drive(1'b1, 8'h03, 8'h00, 2'd3);
        cyc();
        drive(1'b0, 8'h00, 8'h00, 2'd0);
        cyc();
        chk("par_d0",   32'(out_d),   32'h07);
        chk("par_p0",   32'(out_par), 32'd1);
        cyc();
        chk("par_d1",   32'(out_d),   32'h03);
        chk("par_p1",   32'(out_par), 32'd0);
        idle(3);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
